// File: rtl/mem_responder.sv
// Memory-side MemIO endpoint: stores written lines, returns read lines as tagged beat bursts.
// Define MEM_RESPONDER_STATS_EN to add the stat_reads / stat_writes counters.
//
// state     | meaning
// IDLE      | waiting for a command, cmd_ready=1
// WRITE     | accepting write beats into the latched line
// READ_WAIT | counting down READ_LATENCY before the burst
// READ      | emitting one registered beat per cycle
module mem_responder #(
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int BEATS        = 4,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_cmd_ready,
  input  logic                  mem_req_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] mem_req_cmd_addr,
  input  logic [TAG_WIDTH-1:0]  mem_req_cmd_tag,
  input  logic                  mem_req_cmd_rw,
  output logic                  mem_req_data_ready,
  input  logic                  mem_req_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_req_data_data,
  output logic                  mem_resp_valid,
  output logic [DATA_WIDTH-1:0] mem_resp_data,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [TAG_WIDTH-1:0]  mem_resp_tag,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
`else
  output logic [TAG_WIDTH-1:0]  mem_resp_tag
`endif
);

  localparam int BW = $clog2(BEATS);
  localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int AW = DEPTH_LOG2 + BW;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITE     = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  localparam logic [1:0] READ      = 2'd3;

  logic [1:0]            state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [BW-1:0]         beat;
  logic [CW-1:0]         cnt;
  logic                  cmd_fire;
  logic                  data_fire;
  logic                  last_beat;
  logic                  unused_addr_hi;

  logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];

  assign mem_req_cmd_ready  = !reset && (state == IDLE);
  assign mem_req_data_ready = !reset && (state == WRITE);
  assign cmd_fire           = mem_req_cmd_valid && mem_req_cmd_ready;
  assign data_fire          = mem_req_data_valid && mem_req_data_ready;
  assign last_beat          = (beat == BW'(BEATS - 1));
  // Upper address bits alias onto the stored lines.
  assign unused_addr_hi     = ^mem_req_cmd_addr[ADDR_WIDTH-1:DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (data_fire)
      mem[{idx, beat}] <= mem_req_data_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      tag_q          <= '0;
      beat           <= '0;
      cnt            <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      mem_resp_tag   <= '0;
    end else begin
      mem_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            idx  <= mem_req_cmd_addr[DEPTH_LOG2-1:0];
            beat <= '0;
            if (mem_req_cmd_rw) begin
              state <= WRITE;
            end else begin
              tag_q <= mem_req_cmd_tag;
              if (READ_LATENCY > 0) begin
                state <= READ_WAIT;
                cnt   <= CW'(READ_LATENCY);
              end else begin
                state <= READ;
              end
            end
          end
        end
        WRITE: begin
          if (data_fire) begin
            beat <= beat + BW'(1);
            if (last_beat)
              state <= IDLE;
          end
        end
        READ_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= READ;
        end
        READ: begin
          mem_resp_valid <= 1'b1;
          mem_resp_data  <= mem[{idx, beat}];
          mem_resp_tag   <= tag_q;
          beat           <= beat + BW'(1);
          if (last_beat)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      if (cmd_fire && !mem_req_cmd_rw)
        stat_reads <= stat_reads + 32'd1;
      if (data_fire && last_beat)
        stat_writes <= stat_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: randomized line traffic checked every cycle against a line-store model.
// Define MEM_RESPONDER_STATS_EN to also check the statistics counters.
module tb_mem_responder;

  localparam int AW = 26;
  localparam int TW = 5;
  localparam int DW = 128;
  localparam int BEATS = 4;
  localparam int DL = 10;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req_cmd_ready;
  logic          mem_req_cmd_valid = 1'b0;
  logic [AW-1:0] mem_req_cmd_addr = '0;
  logic [TW-1:0] mem_req_cmd_tag = '0;
  logic          mem_req_cmd_rw = 1'b0;
  logic          mem_req_data_ready;
  logic          mem_req_data_valid = 1'b0;
  logic [DW-1:0] mem_req_data_data = '0;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0]   stat_reads;
  logic [31:0]   stat_writes;
`endif

  mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_cmd_ready(mem_req_cmd_ready), .mem_req_cmd_valid(mem_req_cmd_valid),
    .mem_req_cmd_addr(mem_req_cmd_addr), .mem_req_cmd_tag(mem_req_cmd_tag),
    .mem_req_cmd_rw(mem_req_cmd_rw),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_data(mem_req_data_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
`ifdef MEM_RESPONDER_STATS_EN
    .mem_resp_tag(mem_resp_tag), .stat_reads(stat_reads), .stat_writes(stat_writes)
`else
    .mem_resp_tag(mem_resp_tag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } beat_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  logic [DW-1:0] model_mem [int];
  bit            written [int];
  beat_t         expq [$];
  beat_t         cap [$];
  int            wr_line = 0;
  int            wr_beat = 0;
  int            last_rd_edge = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [DW-1:0] hold_data = '0;
  logic [TW-1:0] hold_tag = '0;

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare against the model first, then fold this cycle's handshakes into it.
  always @(negedge clk) begin
    if (started) begin
      bit exp_v;
      exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
      check("resp_valid", DW'(mem_resp_valid), DW'(exp_v));
      if (exp_v) begin
        check("resp_data", mem_resp_data, expq[0].data);
        check("resp_tag", DW'(mem_resp_tag), DW'(expq[0].tag));
        void'(expq.pop_front());
      end else begin
        check("resp_data_hold", mem_resp_data, hold_data);
        check("resp_tag_hold", DW'(mem_resp_tag), DW'(hold_tag));
      end
      if (mem_resp_valid) begin
        cap.push_back('{cyc, mem_resp_data, mem_resp_tag});
        hold_data = mem_resp_data;
        hold_tag  = mem_resp_tag;
      end
    end
    if (reset) begin
      while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
      hold_data = '0;
      hold_tag  = '0;
      rd_cnt    = 0;
      wr_cnt    = 0;
    end else begin
      if (mem_req_cmd_valid && mem_req_cmd_ready) begin
        int line;
        line = int'(mem_req_cmd_addr) % (1 << DL);
        if (mem_req_cmd_rw) begin
          wr_line = line;
          wr_beat = 0;
        end else begin
          last_rd_edge = cyc + 1;
          rd_cnt++;
          for (int k = 0; k < BEATS; k++)
            expq.push_back('{cyc + 2 + RL + k, model_mem[line*BEATS + k], mem_req_cmd_tag});
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        model_mem[wr_line*BEATS + wr_beat] = mem_req_data_data;
        wr_beat++;
        if (wr_beat == BEATS) begin
          wr_cnt++;
          written[wr_line] = 1;
        end
      end
    end
  end

  task automatic timeout(input string name);
    failures++;
    checks++;
    $display("FAIL %s actual=timeout required=handshake t=%0t", name, $time);
  endtask

  task automatic do_cmd(input logic rw, input int addr, input int tag);
    bit done = 0;
    mem_req_cmd_valid = 1'b1;
    mem_req_cmd_rw    = rw;
    mem_req_cmd_addr  = AW'(addr);
    mem_req_cmd_tag   = TW'(tag);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = mem_req_cmd_ready;
      @(posedge clk); #1;
    end
    mem_req_cmd_valid = 1'b0;
    if (!done) timeout("cmd_handshake");
  endtask

  task automatic do_beat(input logic [DW-1:0] d);
    bit done = 0;
    mem_req_data_valid = 1'b1;
    mem_req_data_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = mem_req_data_ready;
      @(posedge clk); #1;
    end
    mem_req_data_valid = 1'b0;
    if (!done) timeout("data_handshake");
  endtask

  task automatic write_line(input int addr, input int tag, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input logic [DW-1:0] d3, input int gap);
    logic [DW-1:0] d [4];
    d = '{d0, d1, d2, d3};
    do_cmd(1'b1, addr, tag);
    for (int b = 0; b < BEATS; b++) begin
      do_beat(d[b]);
      if (b == 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_data_ready", DW'(mem_req_data_ready), DW'(1));
          check("gap_cmd_ready", DW'(mem_req_cmd_ready), DW'(0));
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic read_line(input int addr, input int tag);
    cap.delete();
    do_cmd(1'b0, addr, tag);
    repeat (RL + BEATS + 2) @(posedge clk);
    #1;
  endtask

  task automatic check_cap(input string name, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3, input int tag);
    logic [DW-1:0] d [4];
    d = '{d0, d1, d2, d3};
    check({name, "_nbeats"}, DW'(cap.size()), DW'(BEATS));
    if (cap.size() == BEATS) begin
      check({name, "_first_lat"}, DW'(cap[0].cyc - last_rd_edge), DW'(RL + 1));
      for (int k = 0; k < BEATS; k++) begin
        check({name, "_data"}, cap[k].data, d[k]);
        check({name, "_tag"}, DW'(cap[k].tag), DW'(tag));
        check({name, "_contig"}, DW'(cap[k].cyc - cap[0].cyc), DW'(k));
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cmd_ready", DW'(mem_req_cmd_ready), DW'(0));
    check("rst_data_ready", DW'(mem_req_data_ready), DW'(0));
    check("rst_resp_valid", DW'(mem_resp_valid), DW'(0));
    check("rst_resp_data", mem_resp_data, '0);
    check("rst_resp_tag", DW'(mem_resp_tag), DW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    started = 1;
    @(negedge clk);
    check("idle_cmd_ready", DW'(mem_req_cmd_ready), DW'(1));
    @(posedge clk); #1;

    // basic write then read with fixed latency
    write_line(32'h5, 3, 128'h11, 128'h22, 128'h33, 128'h44, 0);
    read_line(32'h5, 7);
    check_cap("basic", 128'h11, 128'h22, 128'h33, 128'h44, 7);

    // stalled write
    write_line(32'h6, 1, 128'hA1, 128'hA2, 128'hA3, 128'hA4, 2);
    read_line(32'h6, 2);
    check_cap("gap", 128'hA1, 128'hA2, 128'hA3, 128'hA4, 2);

    // aliasing above DEPTH_LOG2
    write_line(32'h405, 4, 128'hB1, 128'hB2, 128'hB3, 128'hB4, 0);
    read_line(32'h005, 9);
    check_cap("alias", 128'hB1, 128'hB2, 128'hB3, 128'hB4, 9);

    // stray write data in IDLE and READ must be ignored
    write_line(32'h20, 0, 128'hA5, 128'hA5, 128'hA5, 128'hA5, 0);
    mem_req_data_valid = 1'b1;
    mem_req_data_data  = 128'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    read_line(32'h6, 11);
    mem_req_data_valid = 1'b0;
    read_line(32'h20, 12);
    check_cap("stray", 128'hA5, 128'hA5, 128'hA5, 128'hA5, 12);

    // reset during beat 1 of a burst
    write_line(32'h30, 0, 128'hC1, 128'hC2, 128'hC3, 128'hC4, 0);
    do_cmd(1'b0, 32'h30, 5);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = mem_resp_valid;
      end
      if (!seen) timeout("reset_first_beat");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_resp_valid", DW'(mem_resp_valid), DW'(0));
    check("rst_mid_cmd_ready", DW'(mem_req_cmd_ready), DW'(0));
`ifdef MEM_RESPONDER_STATS_EN
    check("rst_stat_reads", DW'(stat_reads), DW'(0));
    check("rst_stat_writes", DW'(stat_writes), DW'(0));
`endif
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", DW'(mem_req_cmd_ready), DW'(1));
    @(posedge clk); #1;
    read_line(32'h30, 6);
    check_cap("after_reset", 128'hC1, 128'hC2, 128'hC3, 128'hC4, 6);

    // randomized traffic over a small line pool with aliased upper bits
    for (int it = 0; it < 40; it++) begin
      int line;
      int addr;
      line = 32'h40 + int'($urandom_range(0, 7));
      addr = (int'($urandom_range(0, 255)) << DL) | line;
      if (!written.exists(line) || $urandom_range(0, 1) == 1) begin
        write_line(addr, int'($urandom_range(0, 31)), rnd128(), rnd128(), rnd128(), rnd128(),
                   int'($urandom_range(0, 3)));
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          mem_req_data_valid = 1'b1;
          mem_req_data_data  = rnd128();
        end
        read_line(addr, int'($urandom_range(0, 31)));
        mem_req_data_valid = 1'b0;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", DW'(expq.size()), DW'(0));
`ifdef MEM_RESPONDER_STATS_EN
    check("stat_reads", DW'(stat_reads), DW'(rd_cnt));
    check("stat_writes", DW'(stat_writes), DW'(wr_cnt));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
